// File: rtl/word_rom_sched_if.sv
// Bundle between the two-requester burst scheduler and its environment:
// requests/grants, the shared synchronous-read word memory and the returned word stream.
interface word_rom_sched_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7
);
  logic              req0;
  logic              req1;
  logic [ADDR_W-1:0] base0;
  logic [ADDR_W-1:0] base1;
  logic [ADDR_W-1:0] len0;
  logic [ADDR_W-1:0] len1;
  logic              gnt0;
  logic              gnt1;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;
  logic              rd_id;
  logic              busy;

  // Requesters plus memory model side.
  modport master (
    output req0, req1, base0, base1, len0, len1, mem_rdata,
    input  gnt0, gnt1, mem_en, mem_addr, rd_valid, rd_data, rd_last, rd_id, busy
  );

  // Scheduler side.
  modport slave (
    input  req0, req1, base0, base1, len0, len1, mem_rdata,
    output gnt0, gnt1, mem_en, mem_addr, rd_valid, rd_data, rd_last, rd_id, busy
  );
endinterface

// File: rtl/word_rom_sched.sv
// Round-robin burst scheduler for two requesters sharing one synchronous-read word memory.
// Optional feature macro: WORD_ROM_SCHED_ABORT_EN adds an abort input that cuts a burst short.
module word_rom_sched #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef WORD_ROM_SCHED_ABORT_EN
  input  logic             abort,
`endif
  word_rom_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_r;
  state_t            state_s;
  logic              gnt0_s;
  logic              gnt1_s;
  logic              issue_s;
  logic              last_s;
  logic              stop_s;
  logic              abort_req_s;

  logic              gnt0_r;
  logic              gnt1_r;
  logic [ADDR_W-1:0] base_r;
  logic [ADDR_W-1:0] len_r;
  logic [ADDR_W-1:0] cnt_r;
  logic              id_r;
  logic              last_gnt_r;
  logic              mem_en_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic              mem_last_r;
  logic              rd_valid_r;
  logic              rd_last_r;
  logic              rd_id_r;
  logic              busy_r;

`ifdef WORD_ROM_SCHED_ABORT_EN
  assign abort_req_s = abort;
`else
  assign abort_req_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state, arbitration and issue decisions; on a tie the requester not granted last wins.
  always_comb begin
    state_s = state_r;
    gnt0_s  = 1'b0;
    gnt1_s  = 1'b0;
    issue_s = 1'b0;
    last_s  = 1'b0;
    stop_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.req0 && (!bus.req1 || last_gnt_r)) begin
          gnt0_s  = 1'b1;
          state_s = BURST;
        end else if (bus.req1) begin
          gnt1_s  = 1'b1;
          state_s = BURST;
        end else begin
          state_s = IDLE;
        end
      end
      BURST: begin
        if (abort_req_s) begin
          stop_s  = 1'b1;
          state_s = DRAIN;
        end else begin
          issue_s = 1'b1;
          if (cnt_r == len_r) begin
            last_s  = 1'b1;
            state_s = DRAIN;
          end else begin
            state_s = BURST;
          end
        end
      end
      DRAIN:   state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Burst context, memory issue and returned-stream registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt0_r     <= 1'b0;
      gnt1_r     <= 1'b0;
      base_r     <= ADDR_ZERO;
      len_r      <= ADDR_ZERO;
      cnt_r      <= ADDR_ZERO;
      id_r       <= 1'b0;
      last_gnt_r <= 1'b1;
      mem_en_r   <= 1'b0;
      mem_addr_r <= ADDR_ZERO;
      mem_last_r <= 1'b0;
      rd_valid_r <= 1'b0;
      rd_last_r  <= 1'b0;
      rd_id_r    <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      gnt0_r <= gnt0_s;
      gnt1_r <= gnt1_s;
      if (gnt0_s || gnt1_s) begin
        base_r     <= gnt0_s ? bus.base0 : bus.base1;
        len_r      <= gnt0_s ? bus.len0 : bus.len1;
        id_r       <= gnt1_s;
        last_gnt_r <= gnt1_s;
        cnt_r      <= ADDR_ZERO;
      end else if (issue_s) begin
        cnt_r <= cnt_r + ADDR_ONE;
      end
      mem_en_r <= issue_s;
      if (issue_s) begin
        mem_addr_r <= base_r + cnt_r;
      end
      mem_last_r <= last_s;
      rd_valid_r <= mem_en_r;
      // An abort tags the word already in flight as the last one.
      rd_last_r  <= mem_en_r & (mem_last_r | stop_s);
      if (mem_en_r) begin
        rd_id_r <= id_r;
      end
      busy_r <= (state_s != IDLE);
    end
  end

  assign bus.gnt0     = gnt0_r;
  assign bus.gnt1     = gnt1_r;
  assign bus.mem_en   = mem_en_r;
  assign bus.mem_addr = mem_addr_r;
  assign bus.rd_valid = rd_valid_r;
  assign bus.rd_data  = rd_valid_r ? bus.mem_rdata : {DATA_W{1'b0}};
  assign bus.rd_last  = rd_last_r;
  assign bus.rd_id    = rd_id_r;
  assign bus.busy     = busy_r;

endmodule

// File: tb/tb_word_rom_sched.sv
// Directed bench for word_rom_sched: memory word k holds value k, every check is an immediate assertion.
module tb_word_rom_sched;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 7;

  logic clk;
  logic rst_n;
`ifdef WORD_ROM_SCHED_ABORT_EN
  logic abort;
`endif
  int n_cmp;
  int n_err;

  word_rom_sched_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  word_rom_sched #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef WORD_ROM_SCHED_ABORT_EN
    .abort (abort),
`endif
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory, word k = k.
  always @(posedge clk) begin
    if (bus.mem_en) bus.mem_rdata <= 32'(bus.mem_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt0"}, 32'(bus.gnt0), 32'd0);
    chk({tag, "_gnt1"}, 32'(bus.gnt1), 32'd0);
    chk({tag, "_mem_en"}, 32'(bus.mem_en), 32'd0);
    chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
    chk({tag, "_rd_valid"}, 32'(bus.rd_valid), 32'd0);
    chk({tag, "_rd_data"}, bus.rd_data, 32'd0);
    chk({tag, "_rd_last"}, 32'(bus.rd_last), 32'd0);
    chk({tag, "_rd_id"}, 32'(bus.rd_id), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic wait_grant(output bit got);
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (bus.gnt0 || bus.gnt1) got = 1'b1;
    end
    chk("grant_seen", 32'(got), 32'd1);
  endtask

  // One lone request, then cycle-by-cycle check of addresses, data, flags and busy.
  task automatic run_burst(input bit id, input int base, input int len);
    bit got;
    if (id == 1'b0) begin
      bus.req0 = 1'b1; bus.base0 = 7'(base); bus.len0 = 7'(len);
    end else begin
      bus.req1 = 1'b1; bus.base1 = 7'(base); bus.len1 = 7'(len);
    end
    wait_grant(got);
    chk("burst_gnt0", 32'(bus.gnt0), 32'(id == 1'b0));
    chk("burst_gnt1", 32'(bus.gnt1), 32'(id == 1'b1));
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    if (got) begin
      for (int k = 0; k <= len + 1; k++) begin
        @(negedge clk);
        if (k <= len) begin
          chk("burst_mem_en", 32'(bus.mem_en), 32'd1);
          chk("burst_mem_addr", 32'(bus.mem_addr), 32'((base + k) % 128));
        end else begin
          chk("burst_mem_en_off", 32'(bus.mem_en), 32'd0);
        end
        chk("burst_busy", 32'(bus.busy), 32'(k <= len));
        if (k >= 1) begin
          chk("burst_rd_valid", 32'(bus.rd_valid), 32'd1);
          chk("burst_rd_data", bus.rd_data, 32'((base + k - 1) % 128));
          chk("burst_rd_last", 32'(bus.rd_last), 32'(k - 1 == len));
          chk("burst_rd_id", 32'(bus.rd_id), 32'(id));
        end else begin
          chk("burst_rd_valid_first", 32'(bus.rd_valid), 32'd0);
        end
      end
      @(negedge clk);
      chk("burst_end_rd_valid", 32'(bus.rd_valid), 32'd0);
      chk("burst_end_busy", 32'(bus.busy), 32'd0);
    end
  endtask

  initial begin
    int gid [4];
    int gcyc [4];
    int ng;
    int nv;
    bit got;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.base0 = 7'd0; bus.base1 = 7'd0; bus.len0 = 7'd0; bus.len1 = 7'd0;
    bus.mem_rdata = 32'd0;
`ifdef WORD_ROM_SCHED_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk_all_zero("reset");

    // Both requests held from reset: grants alternate 0,1,0,1 and bursts never overlap.
    bus.req0 = 1'b1; bus.base0 = 7'd40; bus.len0 = 7'd1;
    bus.req1 = 1'b1; bus.base1 = 7'd50; bus.len1 = 7'd2;
    @(negedge clk);
    rst_n = 1'b1;
    chk("first_grant_not_in_release_cycle", 32'(bus.gnt0 | bus.gnt1), 32'd0);
    ng = 0;
    for (int c = 0; c < 60 && ng < 4; c++) begin
      @(negedge clk);
      if (bus.gnt0 || bus.gnt1) begin
        chk("tie_one_hot", 32'(bus.gnt0 & bus.gnt1), 32'd0);
        gid[ng] = int'(bus.gnt1);
        gcyc[ng] = c;
        ng++;
      end
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    chk("tie_grant_count", 32'(ng), 32'd4);
    for (int i = 0; i < ng; i++) chk("tie_order", 32'(gid[i]), 32'(i % 2));
    for (int i = 1; i < ng; i++)
      chk("tie_gap", 32'(gcyc[i] - gcyc[i-1]), (gid[i-1] == 0) ? 32'd4 : 32'd5);
    for (int i = 0; i < 20 && bus.busy; i++) @(negedge clk);
    chk("tie_idle", 32'(bus.busy), 32'd0);

    run_burst(1'b0, 5, 3);
    run_burst(1'b1, 126, 3);
    run_burst(1'b0, 60, 0);
    run_burst(1'b1, 3, 127);

    // Reset pulled during the second returned word of an 8-word burst.
    bus.req0 = 1'b1; bus.base0 = 7'd10; bus.len0 = 7'd7;
    wait_grant(got);
    bus.req0 = 1'b0;
    nv = 0;
    for (int i = 0; i < 10 && nv < 2; i++) begin
      @(negedge clk);
      if (bus.rd_valid) nv++;
    end
    chk("rst_mid_words_seen", 32'(nv), 32'd2);
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nv = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.rd_valid || bus.mem_en) nv++;
    end
    chk("rst_mid_no_valid_after", 32'(nv), 32'd0);

`ifdef WORD_ROM_SCHED_ABORT_EN
    // Abort while the third address is presented: three words, third one last.
    bus.req1 = 1'b1; bus.base1 = 7'd20; bus.len1 = 7'd9;
    wait_grant(got);
    bus.req1 = 1'b0;
    nv = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (bus.rd_valid) nv++;
      if (c == 3) begin
        chk("abort_addr3", 32'(bus.mem_addr), 32'd22);
        abort = 1'b1;
      end
      if (c == 4) begin
        abort = 1'b0;
        chk("abort_mem_en_off", 32'(bus.mem_en), 32'd0);
        chk("abort_rd_data", bus.rd_data, 32'd22);
        chk("abort_rd_last", 32'(bus.rd_last), 32'd1);
        chk("abort_busy_drain", 32'(bus.busy), 32'd1);
      end
      if (c == 5) chk("abort_busy_clear", 32'(bus.busy), 32'd0);
    end
    chk("abort_word_count", 32'(nv), 32'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/word_rom_sched.md
WORD_ROM_SCHED -- requirements
Module: word_rom_sched

Interface
REQ-001 The parameter DATA_W, default 32, SHALL set the operand word width.
REQ-002 The parameter ADDR_W, default 7, SHALL set the word address width; memory depth SHALL be 2**ADDR_W (128 words).
REQ-003 The port clk, input, 1 bit, SHALL be the only clock; all state SHALL update on its rising edge.
REQ-004 The port rst_n, input, 1 bit, SHALL be the asynchronous active-low reset.
REQ-005 The ports req0 and req1, input, 1 bit each, SHALL be the burst requests from requesters 0 and 1.
REQ-006 The ports base0 and base1, input, ADDR_W each, SHALL give the burst start word address.
REQ-007 The ports len0 and len1, input, ADDR_W each, SHALL give the burst length minus one (0..127 means 1..128 words).
REQ-008 The ports gnt0 and gnt1, output, 1 bit each, SHALL each be a one-cycle grant pulse.
REQ-009 The port mem_en, output, 1 bit, SHALL be the read enable of the shared synchronous-read word memory.
REQ-010 The port mem_addr, output, ADDR_W, SHALL be the memory word address.
REQ-011 The port mem_rdata, input, DATA_W, SHALL carry read data one cycle after mem_en.
REQ-012 The outputs rd_valid (1 bit), rd_data (DATA_W), rd_last (1 bit), rd_id (1 bit) and busy (1 bit) SHALL form the returned word stream and the status.

Function
REQ-013 The FSM SHALL have three states: IDLE, BURST and DRAIN.
REQ-014 In IDLE with any request high, the scheduler SHALL assert exactly one grant, latch that requester's base, len and id, and move to BURST.
REQ-015 Arbitration SHALL be round-robin:
  - a lone request wins;
  - on simultaneous requests, the requester not granted last wins;
  - the last-granted pointer resets to 1, so requester 0 wins the first tie.
REQ-016 In BURST, mem_en SHALL be 1 and mem_addr SHALL equal base+i for i = 0..len.
REQ-017 The address SHALL wrap modulo 2**ADDR_W (base 126, len 3 gives 126, 127, 0, 1).
REQ-018 After issuing i == len, the FSM SHALL go to DRAIN for one cycle and then return to IDLE.
REQ-019 rd_valid SHALL be mem_en delayed one cycle, and rd_data SHALL equal mem_rdata whenever rd_valid is 1.
REQ-020 rd_id SHALL equal the latched requester id during valid words.
REQ-021 rd_last SHALL be 1 only with the final word of the burst.
REQ-022 Latency SHALL be as follows:
  - grant in cycle T;
  - addresses in T+1..T+L+1;
  - data in T+2..T+L+2;
  - next grant no earlier than T+L+3 (L = len).
REQ-023 Requests SHALL be ignored outside IDLE.
REQ-024 Requesters SHALL hold req and operands until they receive a grant.
REQ-025 busy SHALL be 1 in BURST and DRAIN and 0 in IDLE.
REQ-026 While not in BURST, mem_addr SHALL hold its last value and mem_en SHALL be 0.

Reset
REQ-027 When rst_n is low, the scheduler SHALL immediately force IDLE and drive these outputs to 0: gnt0, gnt1, mem_en, mem_addr, rd_valid, rd_data, rd_last, rd_id, busy.
REQ-028 A reset asserted mid-burst SHALL discard the burst, and no further rd_valid SHALL appear after release.
REQ-029 The first grant SHALL occur no earlier than the first rising edge after rst_n is released.

Configuration
REQ-030 When the macro WORD_ROM_SCHED_ABORT_EN is defined, the block SHALL add the input abort (1 bit) and the following SHALL apply:
  - abort high in BURST stops issue and goes to DRAIN;
  - the last issued word is returned with rd_last = 1;
  - abort in IDLE or DRAIN has no effect.
REQ-031 When WORD_ROM_SCHED_ABORT_EN is undefined, the abort port SHALL not exist and every burst SHALL run to completion.

Verification
REQ-032 Single burst: req0 with base0 = 5 and len0 = 3 gives gnt0, then mem_addr 5, 6, 7, 8, then four rd_valid words with rd_id = 0 and rd_last on the fourth word.
REQ-033 Tie: req0 and req1 held high from reset give grants in the order 0, 1, 0, 1, with no overlapping bursts.
REQ-034 Wrap: base1 = 126 and len1 = 3 give mem_addr 126, 127, 0, 1, and the memory preloaded with word k = k returns data 126, 127, 0, 1.
REQ-035 Boundary lengths:
  - len = 0 gives one word with rd_valid and rd_last in the same cycle;
  - len = 127 gives 128 words.
REQ-036 Reset mid-burst: rst_n pulled low during word 2 of 8 drops all outputs to 0 at once, and no rd_valid follows release.
REQ-037 With WORD_ROM_SCHED_ABORT_EN defined: abort during the third address of a burst with len = 9 returns three words, the third with rd_last = 1, and busy clears two cycles later.
